// File: rtl/udc_bus_packer_pkg.sv
// udc_pkg: shared constants and slot mapping for the DC-link voltage bus
package udc_pkg;
  localparam int N_SM = 24;
  localparam int UDC_W = 16;
  localparam int UDC_BUS_W = N_SM * UDC_W;
  localparam int IDX_W = 5;
  localparam int TIMEOUT_FRAMES = 3;
  function automatic int slot_lsb(input int i);
    return UDC_W * (N_SM - 1 - i);
  endfunction
endpackage

// File: rtl/udc_bus_packer_if.sv
// udc_bus_packer_if: sample input and published bus signals of the packer
interface udc_bus_packer_if;
  import udc_pkg::*;
  logic                 udc_valid;
  logic [IDX_W-1:0]     udc_idx;
  logic [UDC_W-1:0]     udc_data;
  logic                 frame_sync;
  logic [UDC_BUS_W-1:0] LinkUdc_BUS;
  logic                 bus_valid;
  logic [N_SM-1:0]      stale;
  logic                 all_fresh;
  logic                 idx_err;
  modport slave (
    input  udc_valid, udc_idx, udc_data, frame_sync,
    output LinkUdc_BUS, bus_valid, stale, all_fresh, idx_err
  );
  modport master (
    output udc_valid, udc_idx, udc_data, frame_sync,
    input  LinkUdc_BUS, bus_valid, stale, all_fresh, idx_err
  );
endinterface

// File: rtl/udc_bus_packer_watchdog.sv
// udc_sm_watchdog: per-slot saturating frame-miss counter with registered stale flag
module udc_sm_watchdog #(
  parameter int TIMEOUT_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic upd,
  input  logic frame_sync,
  output logic stale
);
  logic [2:0] r_miss;
  logic [2:0] w_next;
  logic       r_stale;
  always_comb w_next = upd ? 3'd0 : (r_miss == 3'd7 ? 3'd7 : r_miss + 3'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss  <= 3'(TIMEOUT_FRAMES);
      r_stale <= 1'b1;
    end else if (frame_sync) begin
      r_miss  <= w_next;
      r_stale <= w_next >= 3'(TIMEOUT_FRAMES);
    end
  end
  assign stale = r_stale;
endmodule

// File: rtl/udc_bus_packer.sv
// udc_bus_packer: shadow-buffers per-submodule Udc samples and publishes them atomically on frame_sync
module udc_bus_packer
  import udc_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = udc_pkg::TIMEOUT_FRAMES
) (
  input logic             clk,
  input logic             rst,
  udc_bus_packer_if.slave bus
);
  logic [UDC_W-1:0]     r_shadow [N_SM];
  logic [N_SM-1:0]      r_upd;
  logic [N_SM-1:0]      w_hit;
  logic [N_SM-1:0]      w_stale;
  logic [UDC_BUS_W-1:0] r_bus;
  logic                 r_bus_valid;
  logic                 r_idx_err;
  logic                 w_acc;
  assign w_acc = bus.udc_valid && (bus.udc_idx < IDX_W'(N_SM));
  genvar g;
  generate
    for (g = 0; g < N_SM; g++) begin : g_slot
      assign w_hit[g] = w_acc && (bus.udc_idx == IDX_W'(g));
      // a same-cycle write counts as an update for the frame being closed
      udc_sm_watchdog #(.TIMEOUT_FRAMES(TIMEOUT_FRAMES)) u_wd (
        .clk       (clk),
        .rst       (rst),
        .upd       (r_upd[g] | w_hit[g]),
        .frame_sync(bus.frame_sync),
        .stale     (w_stale[g])
      );
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd       <= '0;
      r_bus       <= '0;
      r_bus_valid <= 1'b0;
      r_idx_err   <= 1'b0;
      for (int k = 0; k < N_SM; k++) r_shadow[k] <= '0;
    end else begin
      r_bus_valid <= bus.frame_sync;
      r_idx_err   <= bus.udc_valid && !w_acc;
      r_upd       <= bus.frame_sync ? '0 : (r_upd | w_hit);
      for (int k = 0; k < N_SM; k++) begin
        if (w_hit[k]) r_shadow[k] <= bus.udc_data;
        if (bus.frame_sync) r_bus[slot_lsb(k) +: UDC_W] <= w_hit[k] ? bus.udc_data : r_shadow[k];
      end
    end
  end
  assign bus.LinkUdc_BUS = r_bus;
  assign bus.bus_valid   = r_bus_valid;
  assign bus.idx_err     = r_idx_err;
  assign bus.stale       = w_stale;
  assign bus.all_fresh   = ~|w_stale;
endmodule

// File: doc/udc_bus_packer.md
# udc_bus_packer

Collects per-submodule DC-link voltage samples arriving one at a time from the submodule link receivers and assembles them into the 384-bit `LinkUdc_BUS` consumed by the bus-to-phase unpacking stage. Samples are written into a shadow buffer. On each control-period `frame_sync` the whole buffer is published atomically, so downstream logic never sees a mix of old and new frames. A per-submodule watchdog flags submodules whose samples stop arriving.

## Interface
Parameters:
- `N_SM`, 24, number of submodules (bus slots).
- `UDC_W`, 16, sample width.
- `TIMEOUT_FRAMES`, 3, consecutive frames without update before a slot is marked stale (1..7).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `udc_valid`  in  1  sample strobe, one sample per cycle when high.
- `udc_idx`  in  5  submodule index, 0..23.
- `udc_data`  in  16  sample value, unsigned raw code.
- `frame_sync`  in  1  control-period strobe, single-cycle pulse.
- `LinkUdc_BUS`  out  384  published bus.
- `bus_valid`  out  1  one-cycle pulse marking a new publish.
- `stale`  out  24  `stale[i]` set when submodule index i has timed out.
- `all_fresh`  out  1  high when `stale` is all zero.
- `idx_err`  out  1  one-cycle pulse when an out-of-range index is dropped.

## Operation
- Slot mapping: index i (0-based) occupies `LinkUdc_BUS[16*(23-i)+15 : 16*(23-i)]`. Index 0 maps to bits [383:368] (downstream LinkUdc1). Index 23 maps to bits [15:0] (LinkUdc24).
- Accepted sample (`udc_valid` with idx < 24): written to `shadow[idx]`; `upd[idx]` is set. Repeated writes to the same index within a frame: the last write wins.
- Out-of-range sample (idx 24..31): dropped. `idx_err` pulses. Shadow and `upd` are unchanged.
- On `frame_sync`:
  - `LinkUdc_BUS` ← shadow, including any sample accepted in the same cycle (write-through).
  - `bus_valid` pulses.
  - For each i:
    - if `upd[i]` is set, or a same-cycle write to i occurs: `miss[i]` ← 0.
    - otherwise: `miss[i]` ← min(`miss[i]` + 1, 7).
  - All `upd` bits clear.
- `stale[i]` = (`miss[i]` ≥ `TIMEOUT_FRAMES`), registered.
- A stale slot keeps its last received value on the bus. It is never zeroed.
- `all_fresh` = ~|`stale`, registered together with `stale`.
- Reset values:
  - `LinkUdc_BUS` = 0, shadow = 0, `bus_valid` = 0, `idx_err` = 0.
  - `upd` = 0, `miss[i]` = `TIMEOUT_FRAMES`, so `stale` = 24'hFFFFFF and `all_fresh` = 0.
- Reset in mid-frame discards all pending shadow writes. The next publish after reset carries only samples received after reset.

## Timing
- Sample at cycle t: enters shadow at t+1. Appears on the bus at the first `frame_sync` at or after t.
- `frame_sync` at cycle t: `LinkUdc_BUS`, `bus_valid` (high for cycle t+1 only), `stale` and `all_fresh` all update at t+1.
- `idx_err`: high at t+1 for one cycle.
- Back-to-back `frame_sync` pulses are legal. Each one publishes and advances the miss counters.
- No backpressure: `udc_valid` is always accepted. Throughput is 1 sample/cycle.
- `LinkUdc_BUS` is stable between `bus_valid` pulses.

## Structure
- Package `udc_pkg`:
  - constants `N_SM`, `UDC_W`, `UDC_BUS_W` = `N_SM`*`UDC_W`, `IDX_W` = 5.
  - function `slot_lsb(i)` = 16*(23-i), shared with the unpacking stage.
- Sub-module `udc_sm_watchdog`: one per slot.
  - Inputs: `clk`, `rst`, `upd`, `frame_sync`.
  - Contains the 3-bit saturating miss counter.
  - Output: `stale`.
  - Instantiated `N_SM` times by generate.
- The top level holds the shadow register file, the `upd` mask, the publish register and the index decode.

## Test plan
- Reset: assert `rst` 2 cycles → `LinkUdc_BUS`=0, `stale`=24'hFFFFFF, `all_fresh`=0, `bus_valid`=0.
- Write idx0=16'h1234 and idx23=16'hABCD, then `frame_sync` → at t+1: bus[383:368]=16'h1234, bus[15:0]=16'hABCD, other slots 0, `bus_valid` high for exactly 1 cycle, `stale`=24'h7FFFFE.
- Write all 24 slots with value 16'h0100+i, then sync → `all_fresh`=1. Stop idx 5 and sync 3 more frames → `stale[5]`=1 after the 3rd sync (not the 2nd), slot 5 still 16'h0105, `all_fresh`=0.
- `udc_valid` idx 7=16'h5555 in the same cycle as `frame_sync` → value published at t+1; `stale[7]` clears.
- idx=24 then idx=31 with data 16'hFFFF → two `idx_err` pulses, bus and `stale` unchanged after the next sync.
- Write idx 3=16'h0AAA, assert `rst` before sync, release, then sync → slot 3 = 0, `stale[3]` stays 1.
